// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch datapath and the display mux:
//   FSM state encodings, BCD digit limits, a two-digit BCD field type and
//   BCD increment helpers. A field is a tens/ones pair covering 00..59.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } sw_state_e;

    localparam logic [3:0] MAX_TENS = 4'd5;
    localparam logic [3:0] MAX_ONES = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Per-digit BCD increment: ones 9->0 carries into tens, tens 5->0 wraps.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones == MAX_ONES) begin
            r.ones = 4'd0;
            r.tens = (v.tens == MAX_TENS) ? 4'd0 : v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    // True at 59, i.e. the next increment wraps and carries out.
    function automatic logic bcd_at_max(input bcd2_t v);
        return (v.tens == MAX_TENS) && (v.ones == MAX_ONES);
    endfunction

endpackage

// File: rtl/stopwatch_counter_btn_debounce.sv
// btn_debounce
//   Conditions one raw pushbutton: 2-flop synchronizer, DB_SAMPLES-deep
//   sample history shifted on each tickf strobe, hysteretic debounced level
//   and a one-cycle press pulse on the debounced rising edge.
//   Ports:
//     CLK_REF    in  system clock
//     CLK_RES_N  in  async active-low reset
//     raw        in  asynchronous button level
//     tickf      in  single-cycle debounce sample strobe
//     press      out one-cycle pulse per debounced press (registered)
module btn_debounce #(
    parameter int DB_SAMPLES = 4
) (
    input  logic CLK_REF,
    input  logic CLK_RES_N,
    input  logic raw,
    input  logic tickf,
    output logic press
);

    logic [1:0]            sync;
    logic [DB_SAMPLES-1:0] hist;
    logic                  level;

    always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
        if (!CLK_RES_N) begin
            sync  <= '0;
            hist  <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (tickf)
                hist <= {hist[DB_SAMPLES-2:0], sync[1]};
            // Mixed history keeps the previous level (hysteresis).
            if (&hist)
                level <= 1'b1;
            else if (~|hist)
                level <= 1'b0;
            // Fires on the same edge the level rises; release emits nothing.
            press <= (&hist) & ~level;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   MM:SS time-keeping core. Divider levels are edge-detected into tick
//   pulses, buttons are debounced, switches synchronized. A PAUSED/RUN/ADJUST
//   FSM steps the BCD fields on tick1 (run) or tick2 (adjust).
//   Ports:
//     CLK_REF, CLK_RES_N          clock, async active-low reset
//     CLK_1HZ, CLK_2HZ, CLK_FAST  divider levels (count, adjust/blink, debounce)
//     BTN_PAUSE, BTN_RESET        raw buttons (run/pause toggle, clear)
//     SW_ADJ, SW_SEL              raw switches (adjust mode, 0=min/1=sec)
//     MIN_*/SEC_*                 BCD digits
//     BLANK_MIN, BLANK_SEC        field blank flags for the display
//     RUNNING                     1 while in RUN
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int DB_SAMPLES = 4
) (
    input  logic       CLK_REF,
    input  logic       CLK_RES_N,
    input  logic       CLK_1HZ,
    input  logic       CLK_2HZ,
    input  logic       CLK_FAST,
    input  logic       BTN_PAUSE,
    input  logic       BTN_RESET,
    input  logic       SW_ADJ,
    input  logic       SW_SEL,
    output logic [3:0] MIN_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] SEC_ONES,
    output logic       BLANK_MIN,
    output logic       BLANK_SEC,
    output logic       RUNNING
);

    logic       h1, h2, hf;        // divider level history
    logic       rise1, rise2;      // first edge-detect stage
    logic       tick1, tick2, tickf;
    logic [1:0] adj_sync, sel_sync;
    logic       sw_adj, sw_sel;
    logic       pause_press, rst_press;

    sw_state_e  state_q, state_d;
    logic       blink_q, blink_d;
    bcd2_t      min_q, min_d, sec_q, sec_d;

    // tick1/tick2 take two stages so a digit lands two cycles after the
    // first edge that samples the divider high; tickf only needs one.
    always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
        if (!CLK_RES_N) begin
            {h1, h2, hf}          <= '0;
            {rise1, rise2}        <= '0;
            {tick1, tick2, tickf} <= '0;
            adj_sync              <= '0;
            sel_sync              <= '0;
        end else begin
            h1       <= CLK_1HZ;
            h2       <= CLK_2HZ;
            hf       <= CLK_FAST;
            rise1    <= CLK_1HZ & ~h1;
            rise2    <= CLK_2HZ & ~h2;
            tick1    <= rise1;
            tick2    <= rise2;
            tickf    <= CLK_FAST & ~hf;
            adj_sync <= {adj_sync[0], SW_ADJ};
            sel_sync <= {sel_sync[0], SW_SEL};
        end
    end

    assign sw_adj = adj_sync[1];
    assign sw_sel = sel_sync[1];

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_pause (
        .CLK_REF   (CLK_REF),
        .CLK_RES_N (CLK_RES_N),
        .raw       (BTN_PAUSE),
        .tickf     (tickf),
        .press     (pause_press)
    );

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_reset (
        .CLK_REF   (CLK_REF),
        .CLK_RES_N (CLK_RES_N),
        .raw       (BTN_RESET),
        .tickf     (tickf),
        .press     (rst_press)
    );

    // Ticks are judged against the current state, so a tick coinciding
    // with a mode change still acts in the old mode.
    always_comb begin
        state_d = state_q;
        blink_d = blink_q ^ tick2;
        sec_d   = sec_q;
        min_d   = min_q;

        if (sw_adj) begin
            state_d = ADJUST;
        end else begin
            case (state_q)
                PAUSED:  if (pause_press) state_d = RUN;
                RUN:     if (pause_press) state_d = PAUSED;
                default: state_d = PAUSED;
            endcase
        end

        if (rst_press) begin
            sec_d = '0;
            min_d = '0;
        end else if (state_q == RUN && tick1) begin
            sec_d = bcd_inc(sec_q);
            if (bcd_at_max(sec_q))
                min_d = bcd_inc(min_q);
        end else if (state_q == ADJUST && tick2) begin
            if (sw_sel)
                sec_d = bcd_inc(sec_q);
            else
                min_d = bcd_inc(min_q);
        end
    end

    always_ff @(posedge CLK_REF or negedge CLK_RES_N) begin
        if (!CLK_RES_N) begin
            state_q   <= PAUSED;
            blink_q   <= 1'b0;
            sec_q     <= '0;
            min_q     <= '0;
            RUNNING   <= 1'b0;
            BLANK_MIN <= 1'b0;
            BLANK_SEC <= 1'b0;
        end else begin
            state_q   <= state_d;
            blink_q   <= blink_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            RUNNING   <= (state_d == RUN);
            BLANK_MIN <= (state_d == ADJUST) & ~sw_sel & blink_d;
            BLANK_SEC <= (state_d == ADJUST) &  sw_sel & blink_d;
        end
    end

    assign MIN_TENS = min_q.tens;
    assign MIN_ONES = min_q.ones;
    assign SEC_TENS = sec_q.tens;
    assign SEC_ONES = sec_q.ones;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//   Directed bench for stopwatch_counter. The divider levels are driven by
//   the bench as single-cycle pulses; digits are compared as one 16-bit
//   MM:SS word whose BCD nibbles read directly as hex (02:05 -> 16'h0205).
module tb_stopwatch_counter;

    logic       CLK_REF = 1'b0;
    logic       CLK_RES_N = 1'b0;
    logic       CLK_1HZ = 1'b0, CLK_2HZ = 1'b0, CLK_FAST = 1'b0;
    logic       BTN_PAUSE = 1'b0, BTN_RESET = 1'b0;
    logic       SW_ADJ = 1'b0, SW_SEL = 1'b0;
    logic [3:0] MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
    logic       BLANK_MIN, BLANK_SEC, RUNNING;
    logic [15:0] digits;

    int checks   = 0;
    int failures = 0;

    assign digits = {MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES};

    always #5 CLK_REF = ~CLK_REF;

    stopwatch_counter #(.DB_SAMPLES(4)) dut (
        .CLK_REF   (CLK_REF),
        .CLK_RES_N (CLK_RES_N),
        .CLK_1HZ   (CLK_1HZ),
        .CLK_2HZ   (CLK_2HZ),
        .CLK_FAST  (CLK_FAST),
        .BTN_PAUSE (BTN_PAUSE),
        .BTN_RESET (BTN_RESET),
        .SW_ADJ    (SW_ADJ),
        .SW_SEL    (SW_SEL),
        .MIN_TENS  (MIN_TENS),
        .MIN_ONES  (MIN_ONES),
        .SEC_TENS  (SEC_TENS),
        .SEC_ONES  (SEC_ONES),
        .BLANK_MIN (BLANK_MIN),
        .BLANK_SEC (BLANK_SEC),
        .RUNNING   (RUNNING)
    );

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK_REF);
            #1;
        end
    endtask

    // Returns just after the edge on which the resulting digit change lands.
    task automatic pulse_1hz();
        CLK_1HZ = 1'b1; step(); CLK_1HZ = 1'b0; step(2);
    endtask

    task automatic pulse_2hz();
        CLK_2HZ = 1'b1; step(); CLK_2HZ = 1'b0; step(2);
    endtask

    task automatic strobe();
        CLK_FAST = 1'b1; step(); CLK_FAST = 1'b0; step();
    endtask

    task automatic set_btn(input bit is_reset, input bit v);
        if (is_reset) BTN_RESET = v;
        else          BTN_PAUSE = v;
    endtask

    // Full press and release; returns after the state/digit update.
    task automatic press(input bit is_reset);
        set_btn(is_reset, 1'b1); step(3);
        repeat (4) strobe();
        step(2);
        set_btn(is_reset, 1'b0); step(3);
        repeat (4) strobe();
        step(2);
    endtask

    // Press pulse and tick1 are aligned to reach the counter on one edge.
    task automatic press_with_tick1(input bit is_reset);
        set_btn(is_reset, 1'b1); step(3);
        repeat (3) strobe();
        CLK_FAST = 1'b1; step();
        CLK_FAST = 1'b0; CLK_1HZ = 1'b1; step();
        CLK_1HZ = 1'b0; step(2);
    endtask

    task automatic release_btn(input bit is_reset);
        set_btn(is_reset, 1'b0); step(3);
        repeat (4) strobe();
        step(2);
    endtask

    task automatic hard_reset();
        CLK_RES_N = 1'b0; SW_ADJ = 1'b0; SW_SEL = 1'b0;
        BTN_PAUSE = 1'b0; BTN_RESET = 1'b0;
        step(); CLK_RES_N = 1'b1; step();
    endtask

    task automatic set_sw(input bit adj, input bit sel);
        SW_ADJ = adj; SW_SEL = sel; step(3);
    endtask

    // Load MM:SS through adjust mode, leaving the FSM in PAUSED.
    task automatic preload(input int mins, input int secs);
        set_sw(1'b1, 1'b0);
        repeat (mins) pulse_2hz();
        set_sw(1'b1, 1'b1);
        repeat (secs) pulse_2hz();
        set_sw(1'b0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({digits, BLANK_MIN, BLANK_SEC, RUNNING} !== 19'h0) begin
            failures++;
            $display("FAIL reset_in: got %h %b%b%b expected 0000 000", digits, BLANK_MIN, BLANK_SEC, RUNNING);
        end
        step(2); CLK_RES_N = 1'b1; step(2);
        checks++;
        if ({digits, BLANK_MIN, BLANK_SEC, RUNNING} !== 19'h0) begin
            failures++;
            $display("FAIL reset_out: got %h %b%b%b expected 0000 000", digits, BLANK_MIN, BLANK_SEC, RUNNING);
        end
        pulse_1hz();
        checks++;
        if (digits !== 16'h0000) begin
            failures++;
            $display("FAIL paused_tick: got %h expected 0000", digits);
        end
    endtask

    task automatic test_free_run();
        hard_reset();
        press(1'b0);
        checks++;
        if (RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL run_enter: got RUNNING=%b expected 1", RUNNING);
        end
        pulse_2hz();
        checks++;
        if (digits !== 16'h0000) begin
            failures++;
            $display("FAIL run_tick2: got %h expected 0000", digits);
        end
        // first tick1 with exact latency
        CLK_1HZ = 1'b1; step(); CLK_1HZ = 1'b0; step();
        checks++;
        if (digits !== 16'h0000) begin
            failures++;
            $display("FAIL tick1_early: got %h expected 0000", digits);
        end
        step();
        checks++;
        if (digits !== 16'h0001) begin
            failures++;
            $display("FAIL tick1_latency: got %h expected 0001", digits);
        end
        repeat (124) pulse_1hz();
        checks++;
        if (digits !== 16'h0205 || RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL free_run: got %h run=%b expected 0205 run=1", digits, RUNNING);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h5959; exp_w[1] = 16'h0000; exp_w[2] = 16'h0001;
        hard_reset();
        preload(59, 58);
        checks++;
        if (digits !== 16'h5958) begin
            failures++;
            $display("FAIL wrap_preload: got %h expected 5958", digits);
        end
        press(1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse_1hz();
            checks++;
            if (digits !== exp_w[i]) begin
                failures++;
                $display("FAIL wrap_%0d: got %h expected %h", i, digits, exp_w[i]);
            end
        end
    endtask

    task automatic test_debounce();
        hard_reset();
        repeat (3) begin
            BTN_PAUSE = 1'b1; step(3); repeat (2) strobe();
            BTN_PAUSE = 1'b0; step(3); repeat (2) strobe();
        end
        step(2);
        checks++;
        if (RUNNING !== 1'b0) begin
            failures++;
            $display("FAIL db_glitch: got RUNNING=%b expected 0", RUNNING);
        end
        BTN_PAUSE = 1'b1; step(3); repeat (4) strobe(); step(2);
        checks++;
        if (RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL db_hold: got RUNNING=%b expected 1", RUNNING);
        end
        repeat (2) strobe(); step(2);
        checks++;
        if (RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL db_single: got RUNNING=%b expected 1", RUNNING);
        end
        BTN_PAUSE = 1'b0; step(3); repeat (4) strobe(); step(2);
        checks++;
        if (RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL db_release: got RUNNING=%b expected 1", RUNNING);
        end
    endtask

    task automatic test_adjust();
        logic [15:0] exp_a [3];
        logic        exp_b [3];
        exp_a[0] = 16'h0059; exp_a[1] = 16'h0000; exp_a[2] = 16'h0001;
        exp_b[0] = 1'b1;     exp_b[1] = 1'b0;     exp_b[2] = 1'b1;
        hard_reset();
        set_sw(1'b1, 1'b1);
        repeat (58) pulse_2hz();
        checks++;
        if (digits !== 16'h0058 || BLANK_SEC !== 1'b0) begin
            failures++;
            $display("FAIL adj_preload: got %h bs=%b expected 0058 bs=0", digits, BLANK_SEC);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_2hz();
            checks++;
            if (digits !== exp_a[i] || BLANK_SEC !== exp_b[i] || BLANK_MIN !== 1'b0) begin
                failures++;
                $display("FAIL adj_%0d: got %h bs=%b bm=%b expected %h bs=%b bm=0",
                         i, digits, BLANK_SEC, BLANK_MIN, exp_a[i], exp_b[i]);
            end
        end
        set_sw(1'b0, 1'b1);
        checks++;
        if ({BLANK_MIN, BLANK_SEC, RUNNING} !== 3'b000 || digits !== 16'h0001) begin
            failures++;
            $display("FAIL adj_exit: got %h %b%b%b expected 0001 000", digits, BLANK_MIN, BLANK_SEC, RUNNING);
        end
        pulse_1hz();
        checks++;
        if (digits !== 16'h0001) begin
            failures++;
            $display("FAIL adj_exit_paused: got %h expected 0001", digits);
        end
    endtask

    task automatic test_collisions();
        hard_reset();
        preload(0, 30);
        press(1'b0);
        press_with_tick1(1'b1);
        checks++;
        if (digits !== 16'h0000 || RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_tick: got %h run=%b expected 0000 run=1", digits, RUNNING);
        end
        release_btn(1'b1);
        hard_reset();
        preload(0, 10);
        press(1'b0);
        press_with_tick1(1'b0);
        checks++;
        if (digits !== 16'h0011 || RUNNING !== 1'b0) begin
            failures++;
            $display("FAIL pause_vs_tick: got %h run=%b expected 0011 run=0", digits, RUNNING);
        end
        release_btn(1'b0);
    endtask

    task automatic test_async_reset();
        hard_reset();
        preload(3, 17);
        press(1'b0);
        checks++;
        if (digits !== 16'h0317 || RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL ar_preload: got %h run=%b expected 0317 run=1", digits, RUNNING);
        end
        #2; CLK_RES_N = 1'b0; #1;
        checks++;
        if ({digits, BLANK_MIN, BLANK_SEC, RUNNING} !== 19'h0) begin
            failures++;
            $display("FAIL ar_immediate: got %h %b%b%b expected 0000 000", digits, BLANK_MIN, BLANK_SEC, RUNNING);
        end
        step(); CLK_RES_N = 1'b1; step();
        pulse_1hz();
        checks++;
        if (digits !== 16'h0000 || RUNNING !== 1'b0) begin
            failures++;
            $display("FAIL ar_paused: got %h run=%b expected 0000 run=0", digits, RUNNING);
        end
        press(1'b0);
        pulse_1hz();
        checks++;
        if (digits !== 16'h0001 || RUNNING !== 1'b1) begin
            failures++;
            $display("FAIL ar_resume: got %h run=%b expected 0001 run=1", digits, RUNNING);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_wrap();
        test_debounce();
        test_adjust();
        test_collisions();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping core of the stopwatch, directly downstream of the clock divider. Consumes the divider's CLK_1HZ, CLK_2HZ and CLK_FAST levels as enables in the CLK_REF domain and maintains an MM:SS count with run/pause/clear/adjust control from board buttons and switches. Drives BCD digits and per-field blank flags to the display multiplexer.

## Interface
- DB_SAMPLES, 4: consecutive equal CLK_FAST samples required to change a debounced button level.
- CLK_REF  in  1  system clock. The divider's outputs are synchronous to it.
- CLK_RES_N  in  1  reset. Asynchronous assert, active-low.
- CLK_1HZ  in  1  divider 1 Hz level. Each rising edge is one count tick.
- CLK_2HZ  in  1  divider 2 Hz level. Rising edges drive adjust steps and blink phase.
- CLK_FAST  in  1  divider fast level. Rising edges are debounce sample strobes.
- BTN_PAUSE  in  1  raw pushbutton, asynchronous. Toggles run/pause.
- BTN_RESET  in  1  raw pushbutton, asynchronous. Clears count.
- SW_ADJ  in  1  raw switch, asynchronous. 1 = adjust mode.
- SW_SEL  in  1  raw switch, asynchronous. In adjust mode: 0 = minutes, 1 = seconds.
- MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES  out  4 each  BCD digits. Tens digits are 0–5.
- BLANK_MIN, BLANK_SEC  out  1 each  1 = display blanks that field.
- RUNNING  out  1  1 while in state RUN.

## Operation
- Input conditioning:
  - All four raw inputs pass through 2-flop synchronizers.
  - Divider inputs are edge-detected with one history register each. tick1/tick2/tickf are single-cycle pulses.
- Debounce (buttons only):
  - On each tickf, shift the synced level into a DB_SAMPLES-bit history.
  - All ones → debounced level = 1. All zeros → debounced level = 0. Otherwise hold.
  - A debounced 0→1 transition produces a one-cycle press pulse. Release produces nothing.
- Switches are used synchronized, without debounce.
- FSM states: PAUSED (reset state), RUN, ADJUST.
  - Any state with SW_ADJ=1 → ADJUST.
  - ADJUST with SW_ADJ=0 → PAUSED.
  - PAUSED + pause press → RUN.
  - RUN + pause press → PAUSED.
  - Pause press in ADJUST is ignored.
- Counting:
  - RUN + tick1: increment seconds.
  - SEC 59 → 00 carries +1 to minutes.
  - MIN 59 → 00 with no further carry, so 59:59 → 00:00.
- Adjust:
  - ADJUST + tick2: increment the selected field only.
  - Wrap 59 → 00 with no carry into the other field.
- Clear: a reset press sets all digits to 0 in any state. The state is unchanged.
- Simultaneous events:
  - Reset press and tick1/tick2 in the same cycle: clear wins.
  - Pause press and tick1 in RUN: the increment is applied and the state goes to PAUSED.
  - SW_ADJ change and tick in the same cycle: the tick is evaluated in the pre-transition state.
- Blink:
  - blink_ph toggles on every tick2.
  - BLANK_MIN = (state==ADJUST) & ~SW_SEL & blink_ph.
  - BLANK_SEC = (state==ADJUST) & SW_SEL & blink_ph.
- Arithmetic: per-digit BCD. Ones digit wraps 9→0 with carry into tens. Tens digit wraps 5→0 with carry out. No binary-to-BCD conversion.

## Timing
- Reset values:
  - All digits 0.
  - BLANK_MIN=0, BLANK_SEC=0, RUNNING=0.
  - State PAUSED, blink_ph=0.
  - Synchronizers, edge history and debounce histories all 0.
- All outputs are registered.
- tick1 latency: the digit change is visible 2 CLK_REF cycles after the first CLK_REF edge that samples CLK_1HZ high. tick2 has the same latency.
- Button latency:
  - 2 sync cycles, then DB_SAMPLES tickf strobes with the level stable.
  - Then 1 cycle to the press pulse, then 1 cycle to the state or digit update.
- RUNNING changes in the same cycle as the state register.
- Reset assertion mid-count clears everything immediately, asynchronously. The first tick after deassertion is honoured normally.

## Structure
- Shared package `stopwatch_pkg`:
  - State encodings: PAUSED=2'd0, RUN=2'd1, ADJUST=2'd2.
  - Constants MAX_TENS=4'd5, MAX_ONES=4'd9.
  - Reused by the display mux.
- Sub-module `btn_debounce` (params DB_SAMPLES). Ports: CLK_REF, CLK_RES_N, raw, tickf, press. It contains the synchronizer, sample history and edge pulse.
- Instantiate it twice.

## Test plan
- Free run: reset, pause press, 125 tick1 → 02:05. RUNNING=1. Digits step only on tick1.
- Wrap: preload 59:58 via adjust, then run 3 tick1 → 59:59, 00:00, 00:01.
- Debounce: BTN_PAUSE glitches high for 2 tickf then low, repeated → no state change. Hold high for 4 tickf → exactly one RUN transition. Release → no event.
- Adjust: SW_ADJ=1, SW_SEL=1 from 00:58, 3 tick2 → 00:59, 00:00, 00:01 with minutes unchanged. BLANK_SEC toggles each tick2. BLANK_MIN=0. SW_ADJ=0 → PAUSED, blanks 0.
- Collisions: reset press coincident with tick1 at 00:30 → 00:00. Pause press coincident with tick1 at 00:10 → 00:11 and PAUSED.
- Async reset mid-run at 03:17 → all outputs 0 within the same cycle. After deassertion, state is PAUSED and tick1 is ignored until a pause press.
